fractal_job_scheduler: RTL and testbench



---
 rtl/fractal_job_scheduler.sv | 172 +++++++++++++++++
 tb/tb_fractal_job_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_job_scheduler.sv
// Round-robin job scheduler sharing one fractal_kernel between NUM_REQ requesters.
// One job in flight: grant, issue, wait for result or timeout, then respond.
module fractal_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*256-1:0]  req_pixel,
    input  logic [NUM_REQ*32-1:0]   req_config,
    output logic                    kern_start,
    output logic                    kern_abort,
    output logic [255:0]            kern_pixel_block,
    output logic [31:0]             kern_config,
    input  logic                    kern_valid,
    input  logic [127:0]            kern_coeff,
    input  logic                    kern_quantum_valid,
    input  logic [63:0]             kern_quantum_state,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [127:0]            rsp_coeff,
    output logic [63:0]             rsp_quantum_state,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [7:0]              stale_count
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [255:0]       pixel_q, pixel_d;
    logic [31:0]        cfg_q, cfg_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [127:0]       coeff_q, coeff_d;
    logic [63:0]        qstate_q, qstate_d;
    logic               tout_q, tout_d;
    logic [7:0]         stale_q, stale_d;

    logic [ID_W-1:0]    grant;
    logic               grant_vld;
    logic [ID_W:0]      scan_idx;
    logic [ID_W:0]      next_ptr;
    logic [NUM_REQ-1:0] ready_w;

    // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_vld && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant     = scan_idx[ID_W-1:0];
            end
        end
        next_ptr = {1'b0, grant} + (ID_W+1)'(1);
        if (next_ptr == (ID_W+1)'(NUM_REQ)) begin
            next_ptr = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        timer_d    = timer_q;
        pixel_d    = pixel_q;
        cfg_d      = cfg_q;
        id_d       = id_q;
        coeff_d    = coeff_q;
        qstate_d   = qstate_q;
        tout_d     = tout_q;
        stale_d    = stale_q;
        ready_w    = '0;
        kern_start = 1'b0;
        kern_abort = 1'b0;

        if (kern_valid && (state_q != S_WAIT) && (stale_q != 8'hFF)) begin
            stale_d = stale_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    ready_w[grant] = 1'b1;
                    pixel_d        = req_pixel[grant*256 +: 256];
                    cfg_d          = req_config[grant*32 +: 32];
                    id_d           = grant;
                    rr_ptr_d       = next_ptr[ID_W-1:0];
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                kern_start = 1'b1;
                timer_d    = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A result on the timeout cycle takes priority over the abort.
                if (kern_valid) begin
                    coeff_d  = kern_coeff;
                    tout_d   = 1'b0;
                    qstate_d = (cfg_q[25] && kern_quantum_valid) ? kern_quantum_state : '0;
                    state_d  = S_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES-1)) begin
                    kern_abort = 1'b1;
                    coeff_d    = '0;
                    qstate_d   = '0;
                    tout_d     = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            timer_q  <= '0;
            pixel_q  <= '0;
            cfg_q    <= '0;
            id_q     <= '0;
            coeff_q  <= '0;
            qstate_q <= '0;
            tout_q   <= 1'b0;
            stale_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            timer_q  <= timer_d;
            pixel_q  <= pixel_d;
            cfg_q    <= cfg_d;
            id_q     <= id_d;
            coeff_q  <= coeff_d;
            qstate_q <= qstate_d;
            tout_q   <= tout_d;
            stale_q  <= stale_d;
        end
    end

    // Ready is combinational from req_valid, so hold it low while reset is asserted.
    assign req_ready         = ready_w & {NUM_REQ{rst_n}};
    assign kern_pixel_block  = pixel_q;
    assign kern_config       = cfg_q;
    assign rsp_valid         = (state_q == S_RESP);
    assign rsp_id            = id_q;
    assign rsp_coeff         = coeff_q;
    assign rsp_quantum_state = qstate_q;
    assign rsp_timeout       = tout_q;
    assign busy              = (state_q != S_IDLE);
    assign stale_count       = stale_q;

endmodule

// File: tb/tb_fractal_job_scheduler.sv
// Bench for fractal_job_scheduler: directed steps plus randomized jobs against a job-level model.
module tb_fractal_job_scheduler;

    localparam int N = 4;
    localparam int T = 8;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*256-1:0]  req_pixel;
    logic [N*32-1:0]   req_config;
    logic              kern_start;
    logic              kern_abort;
    logic [255:0]      kern_pixel_block;
    logic [31:0]       kern_config;
    logic              kern_valid;
    logic [127:0]      kern_coeff;
    logic              kern_quantum_valid;
    logic [63:0]       kern_quantum_state;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [127:0]      rsp_coeff;
    logic [63:0]       rsp_quantum_state;
    logic              rsp_timeout;
    logic              busy;
    logic [7:0]        stale_count;

    fractal_job_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_pixel          (req_pixel),
        .req_config         (req_config),
        .kern_start         (kern_start),
        .kern_abort         (kern_abort),
        .kern_pixel_block   (kern_pixel_block),
        .kern_config        (kern_config),
        .kern_valid         (kern_valid),
        .kern_coeff         (kern_coeff),
        .kern_quantum_valid (kern_quantum_valid),
        .kern_quantum_state (kern_quantum_state),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_id             (rsp_id),
        .rsp_coeff          (rsp_coeff),
        .rsp_quantum_state  (rsp_quantum_state),
        .rsp_timeout        (rsp_timeout),
        .busy               (busy),
        .stale_count        (stale_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int model_rr = 0;
    int exp_stale = 0;
    logic [255:0] pix [N];
    logic [31:0]  cfg [N];

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_pixel[i*256 +: 256] = pix[i];
            req_config[i*32 +: 32]  = cfg[i];
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_start"}, kern_start, 0);
        chk({tag, "_abort"}, kern_abort, 0);
        chk({tag, "_kpix"}, kern_pixel_block, 0);
        chk({tag, "_kcfg"}, kern_config, 0);
        chk({tag, "_rvalid"}, rsp_valid, 0);
        chk({tag, "_rid"}, rsp_id, 0);
        chk({tag, "_rcoeff"}, rsp_coeff, 0);
        chk({tag, "_rq"}, rsp_quantum_state, 0);
        chk({tag, "_rto"}, rsp_timeout, 0);
        chk({tag, "_stale"}, stale_count, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        model_rr  = 0;
        exp_stale = 0;
        #1;
    endtask

    // lat = WAIT cycles before kern_valid; lat >= T means the kernel stays silent.
    task automatic run_job(input logic [N-1:0] vmask, input int lat, input logic qv,
                           input logic [63:0] qst, input logic [127:0] coeff,
                           input int rdy, input bit spur, output int gid);
        int g;
        bit found;
        bit done;
        logic to;
        logic [255:0] jp;
        logic [31:0] jc;
        logic [127:0] ec;
        logic [63:0] eq;
        g = 0;
        found = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && vmask[(model_rr + k) % N]) begin
                found = 1;
                g = (model_rr + k) % N;
            end
        end
        jp = pix[g];
        jc = cfg[g];
        drive_reqs();
        req_valid = vmask;
        #1;
        chk("grant_ready", req_ready, 1 << g);
        tick();
        model_rr = (g + 1) % N;
        pix[g] = rand256();
        cfg[g] = $urandom;
        drive_reqs();
        #1;
        chk("issue_start", kern_start, 1);
        chk("issue_pixel", kern_pixel_block, jp);
        chk("issue_config", kern_config, jc);
        chk("issue_ready", req_ready, 0);
        to = 1'b1;
        done = 0;
        for (int t = 0; t < T && !done; t++) begin
            tick();
            kern_valid         = (t == lat);
            kern_coeff         = coeff;
            kern_quantum_valid = qv;
            kern_quantum_state = qst;
            #1;
            chk("wait_abort", kern_abort, (t == T-1) && (t != lat));
            chk("wait_start", kern_start, 0);
            chk("wait_ready", req_ready, 0);
            if (t == lat) begin
                to = 1'b0;
                done = 1;
            end else if (t == T-1) begin
                done = 1;
            end
        end
        ec = to ? 128'd0 : coeff;
        eq = (!to && jc[25] && qv) ? qst : 64'd0;
        gid = -1;
        for (int d = 0; d <= rdy; d++) begin
            tick();
            kern_valid         = spur && (d == 0);
            kern_coeff         = rand256();
            kern_quantum_valid = 1'b1;
            kern_quantum_state = rand256();
            if (kern_valid && exp_stale < 255) exp_stale++;
            rsp_ready = (d == rdy);
            #1;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, g);
            chk("rsp_coeff", rsp_coeff, ec);
            chk("rsp_qstate", rsp_quantum_state, eq);
            chk("rsp_timeout", rsp_timeout, to);
            chk("rsp_ready_mask", req_ready, 0);
            chk("rsp_kcfg", kern_config, jc);
            gid = rsp_id;
        end
        tick();
        kern_valid = 1'b0;
        kern_quantum_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("post_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_stale", stale_count, exp_stale);
    endtask

    initial begin
        int gid;
        int r;
        int lat;
        logic [N-1:0] vm;
        rst_n = 1'b0;
        req_valid = '0;
        req_pixel = '0;
        req_config = '0;
        kern_valid = 1'b0;
        kern_coeff = '0;
        kern_quantum_valid = 1'b0;
        kern_quantum_state = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            pix[i] = rand256();
            cfg[i] = $urandom;
        end

        // Single job with the minimum-latency kernel answer.
        do_reset();
        pix[0] = {32{8'hA5}};
        cfg[0] = 32'h0000_0A08;
        run_job(4'b0001, 0, 1'b0, 64'd0, 128'h1234, 0, 0, gid);
        chk("t1_id", gid, 0);
        req_valid = '0;

        // All requesters held valid: grants rotate.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_job(4'b1111, 0, 1'b0, 64'd0, rand256(), 0, 0, gid);
            chk("t2_rr_seq", gid, k % N);
        end
        req_valid = '0;

        // Silent kernel, then a result on the timeout cycle.
        run_job(4'b0100, T, 1'b0, 64'd0, rand256(), 0, 0, gid);
        run_job(4'b0100, T-1, 1'b0, 64'd0, 128'hCAFE_F00D, 0, 0, gid);

        // Quantum state passes only when config[25] is set.
        cfg[1] = $urandom | 32'h0200_0000;
        run_job(4'b0010, 1, 1'b1, 64'hDEAD_BEEF_0123_4567, rand256(), 0, 0, gid);
        cfg[1] = cfg[1] & ~32'h0200_0000;
        run_job(4'b0010, 1, 1'b1, 64'hDEAD_BEEF_0123_4567, rand256(), 0, 0, gid);

        // Back-pressured response, other requesters waiting.
        run_job(4'b1111, 2, 1'b0, 64'd0, rand256(), 20, 1, gid);
        req_valid = '0;

        // Spurious kern_valid in IDLE, then saturation.
        do_reset();
        kern_valid = 1'b1;
        tick();
        kern_valid = 1'b0;
        #1;
        chk("stale_one", stale_count, 1);
        kern_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        kern_valid = 1'b0;
        #1;
        chk("stale_sat", stale_count, 255);

        // Reset asserted while a job waits on the kernel.
        do_reset();
        pix[0] = rand256();
        drive_reqs();
        req_valid = 4'b0001;
        tick();
        tick();
        #1;
        chk("rw_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_wait");
        tick();
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        #1;
        for (int i = 0; i < T + 4; i++) begin
            tick();
            #1;
            chk("rw_no_rsp", rsp_valid, 0);
            chk("rw_no_abort", kern_abort, 0);
            chk("rw_idle", busy, 0);
        end
        model_rr = 0;
        exp_stale = 0;

        // Randomized jobs.
        for (int j = 0; j < 40; j++) begin
            vm = 4'($urandom_range(1, 15));
            r = $urandom_range(0, 9);
            lat = (r >= T) ? T : r;
            run_job(vm, lat, 1'($urandom_range(0, 1)), {$urandom, $urandom}, rand256(),
                    $urandom_range(0, 3), bit'($urandom_range(0, 1)), gid);
            if ($urandom_range(0, 1) == 1) req_valid = '0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
